raddr_channel: RTL and testbench
================================

// Module: raddr_channel
// PURPOSE
//   AXI read-address generator for the frame-fetch path. On start_pulse it issues one
//   1-beat AR for the parameter block, then one 3-beat AR per macroblock (Y0, Y1, UV).
//   Feeds the read-data stage, which consumes beat 0 as parameters and then 3-beat groups.
//   Caps outstanding bursts; flags done once every requested burst has returned its rlast.
// PARAMETERS
//   ID_WIDTH        2   AXI ID width; arid is constant 0, so all returns stay in order
//   ADDR_WIDTH      64  AXI address width
//   MAX_OUTSTANDING 4   max AR bursts issued without an rlast (1..15)
// PORTS
//   clk            in   1           clock
//   rst_n          in   1           async active-low reset
//   start_pulse    in   1           1-cycle start; ignored while busy
//   src_base_addr  in   ADDR_WIDTH  frame base; bits[8:0] ignored (treated as 0)
//   mb_total       in   16          macroblock count, sampled on start_pulse
//   busy           out  1           high from the cycle after an accepted start until done
//   done           out  1           1-cycle pulse when the job completes
//   m_axi_araddr   out  ADDR_WIDTH  burst address
//   m_axi_arlen    out  8           0 = param burst, 2 = MB burst
//   m_axi_arsize   out  3           constant 3'b111 (128 B/beat)
//   m_axi_arburst  out  2           constant 2'b01 (INCR)
//   m_axi_arid     out  ID_WIDTH    constant 0
//   m_axi_arvalid  out  1           AR valid
//   m_axi_arready  in   1           AR ready
//   m_axi_rvalid   in   1           R snoop, used for outstanding tracking
//   m_axi_rready   in   1           R snoop (driven by the read-data stage)
//   m_axi_rlast    in   1           R snoop
// BEHAVIOUR
//   Reset: all outputs 0 (arsize/arburst constants excepted), FSM IDLE, counters 0.
//   Address map: base = {src_base_addr[AW-1:9],9'b0}. Param at base. MB i (0-based) at
//     base + 512*(i+1). Stride 512 B, so a 384 B burst never crosses a 4 KB boundary.
//   FSM:
//     IDLE   : on start_pulse, latch base and mb_total, set busy -> PARAM.
//     PARAM  : arvalid=1, araddr=base, arlen=0. On arready -> MB, or DRAIN if mb_total==0.
//     MB     : arvalid=1 while outstanding<MAX_OUTSTANDING, arlen=2.
//              On handshake: mb_idx++. After the last MB handshake -> DRAIN.
//     DRAIN  : wait until outstanding==0, then pulse done, clear busy -> IDLE.
//   Latency: start_pulse in cycle T gives busy=1 and arvalid=1 in T+1.
//   Handshake rules:
//     - araddr, arlen and arvalid are registered.
//     - Once arvalid is asserted, araddr/arlen stay stable and arvalid stays high
//       until arready is sampled high.
//     - arvalid is never dropped without a handshake; the outstanding cap is checked
//       only before asserting arvalid.
//     - Back-to-back ARs are allowed: a new arvalid in the cycle after a handshake,
//       provided the cap permits.
//   Outstanding counter (4 bits):
//     - +1 on AR handshake; -1 on (rvalid & rready & rlast); unchanged if both occur
//       in the same cycle.
//     - The cap counts the param burst.
//     - Underflow (rlast with count 0) is ignored; the count stays 0.
//   mb_idx is a 16-bit counter. The address is computed at full ADDR_WIDTH, with no
//     wrap at 16 bits.
//   start_pulse while busy: ignored; latched values are unchanged.
//   Reset mid-job: immediate return to IDLE with all state cleared; no done pulse.
//   done and start_pulse in the same cycle: start is ignored (busy is still high).
// TESTING
//   1. base=0x1000_0000, mb_total=2, arready=1, R returns promptly:
//      -> ARs (0x1000_0000,len0), (0x1000_0200,len2), (0x1000_0400,len2)
//      -> one done pulse after the third rlast.
//   2. mb_total=0 -> a single param AR only; done one cycle after its rlast.
//   3. mb_total=8, MAX_OUTSTANDING=4, no R returns:
//      -> exactly 4 ARs, then arvalid stays low.
//      -> each rlast releases exactly one more AR.
//   4. arready held low for 5 cycles -> araddr/arlen/arvalid remain stable for all
//      5 cycles, with no duplicate issue.
//   5. base=0x1000_01FF -> the param AR goes to 0x1000_0000.
//      An AR handshake coinciding with an rlast leaves the outstanding count unchanged.
//   6. rst_n asserted after 2 of 5 MB ARs -> all outputs go to 0 immediately.
//      A new start then restarts from the param AR.

Source files
------------

// File: rtl/raddr_channel.sv
// raddr_channel: AXI read-address generator for the frame-fetch path.
// Issues one 1-beat parameter burst followed by one 3-beat burst per macroblock.
// It limits the number of bursts in flight, and it pulses done once every burst has returned rlast.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start_pulse; the busy flag clears here after done
// PARAM  | parameter AR (len 0) presented at the base address
// MB     | macroblock ARs (len 2), gated by the outstanding cap
// DRAIN  | all ARs issued; waiting for the outstanding count to reach 0
module raddr_channel #(
    parameter int ID_WIDTH        = 2,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_pulse,
    input  logic [ADDR_WIDTH-1:0] src_base_addr,
    input  logic [15:0]           mb_total,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic                  m_axi_rready,
    input  logic                  m_axi_rlast
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PARAM = 2'd1,
        S_MB    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    state_t                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  arvalid_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]            arlen_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [15:0]           mb_total_q;
    logic [15:0]           mb_idx_q;
    logic [3:0]            out_q;
    logic [3:0]            out_d;

    logic                  ar_hs;
    logic                  r_last_hs;
    logic                  cap_ok;
    logic [ADDR_WIDTH-1:0] base_in;
    logic                  unused_low_bits;

    // The low 9 address bits are forced to zero, so each 512 B slot is aligned
    assign base_in         = {src_base_addr[ADDR_WIDTH-1:9], 9'b0};
    assign unused_low_bits = ^src_base_addr[8:0];

    assign ar_hs     = arvalid_q & m_axi_arready;
    // An rlast seen while nothing is outstanding is ignored, so the count never underflows
    assign r_last_hs = m_axi_rvalid & m_axi_rready & m_axi_rlast & (out_q != 4'd0);
    // The cap is evaluated on next cycle's count; a new AR may follow a handshake back-to-back
    assign cap_ok    = (out_d < MAX_OUT);

    // Slot 0 holds the parameter block; macroblock i lives in slot i+1
    function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [ADDR_WIDTH-1:0] b,
                                                        input logic [16:0] slot);
        return b + ({{(ADDR_WIDTH-17){1'b0}}, slot} << 9);
    endfunction

    // Next outstanding count: +1 per AR handshake, -1 per returned rlast, unchanged when both occur
    always_comb begin
        out_d = out_q;
        if (ar_hs && !r_last_hs) begin
            out_d = out_q + 4'd1;
        end else if (!ar_hs && r_last_hs) begin
            out_d = out_q - 4'd1;
        end
    end

    // Sequencer: the FSM plus registered AR channel, busy and done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= 8'd0;
            base_q     <= '0;
            mb_total_q <= 16'd0;
            mb_idx_q   <= 16'd0;
            out_q      <= 4'd0;
        end else begin
            done_q <= 1'b0;
            out_q  <= out_d;
            case (state_q)
                S_IDLE: begin
                    // busy_q is still high only in the done cycle, so a start arriving then is dropped
                    if (start_pulse && !busy_q) begin
                        base_q     <= base_in;
                        mb_total_q <= mb_total;
                        mb_idx_q   <= 16'd0;
                        busy_q     <= 1'b1;
                        arvalid_q  <= 1'b1;
                        araddr_q   <= base_in;
                        arlen_q    <= 8'd0;
                        state_q    <= S_PARAM;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_PARAM: begin
                    if (ar_hs) begin
                        if (mb_total_q == 16'd0) begin
                            arvalid_q <= 1'b0;
                            state_q   <= S_DRAIN;
                        end else begin
                            araddr_q  <= slot_addr(base_q, 17'd1);
                            arlen_q   <= 8'd2;
                            arvalid_q <= cap_ok;
                            state_q   <= S_MB;
                        end
                    end
                end
                S_MB: begin
                    if (ar_hs) begin
                        mb_idx_q <= mb_idx_q + 16'd1;
                        if (16'(mb_idx_q + 16'd1) == mb_total_q) begin
                            arvalid_q <= 1'b0;
                            state_q   <= S_DRAIN;
                        end else begin
                            araddr_q  <= slot_addr(base_q, {1'b0, mb_idx_q} + 17'd2);
                            arvalid_q <= cap_ok;
                        end
                    end else if (!arvalid_q) begin
                        // araddr_q already points at the pending macroblock
                        arvalid_q <= cap_ok;
                    end
                end
                S_DRAIN: begin
                    if (out_d == 4'd0) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'b111;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arid    = '0;
    assign m_axi_arvalid = arvalid_q;

endmodule

// File: tb/tb_raddr_channel.sv
// tb_raddr_channel: randomized bench for raddr_channel with a job-level reference model.
module tb_raddr_channel;

    localparam int AW   = 64;
    localparam int IW   = 2;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_pulse = 1'b0;
    logic [AW-1:0] src_base_addr = '0;
    logic [15:0]   mb_total = 16'd0;
    logic          busy, done;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [IW-1:0] arid;
    logic          arvalid;
    logic          arready = 1'b0;
    logic          rvalid = 1'b0;
    logic          rready = 1'b0;
    logic          rlast = 1'b0;

    raddr_channel #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse),
        .src_base_addr(src_base_addr), .mb_total(mb_total),
        .busy(busy), .done(done),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arid(arid), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axi_rlast(rlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t         exp_q[$];      // ARs the current job still has to issue, in order
    int          rq[$];         // beats still to return per accepted burst
    logic [63:0] log_addr[$];   // addresses of accepted ARs in the current job

    int n_pass  = 0;
    int n_total = 0;

    bit          m_busy = 0, m_done = 0, m_active = 0, prev_stall = 0;
    int          cnt = 0, hs_count = 0;
    logic [63:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;

    int          ar_mode = 0;   // 0: arready=1, 1: random, 2: held low
    int          r_mode  = 1;   // 0: no returns, 1: prompt, 2: random with stray rlasts
    bit          go = 0, spur_en = 0;
    logic [63:0] job_base = '0;
    logic [15:0] job_n = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: compare this cycle's outputs, then advance the job state using this cycle's inputs.
    always @(negedge clk) begin
        bit  hs, rl, dec, exp_v, nd, cur_busy;
        ar_t e;
        logic [63:0] b;
        if (!rst_n) begin
            exp_q.delete(); rq.delete();
            cnt = 0; m_busy = 0; m_done = 0; m_active = 0; prev_stall = 0;
        end else begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (prev_stall) begin
                chk("hold_valid", arvalid, 1);
                chk("hold_addr", araddr, prev_addr);
                chk("hold_len", arlen, prev_len);
            end else begin
                exp_v = m_active && exp_q.size() > 0 && cnt < MAXO;
                chk("arvalid", arvalid, exp_v);
            end
            if (arvalid) begin
                if (exp_q.size() == 0) chk("ar_extra", arvalid, 0);
                else begin
                    chk("araddr", araddr, exp_q[0].addr);
                    chk("arlen", arlen, exp_q[0].len);
                end
            end
            hs = arvalid && arready;
            rl = rvalid && rready && rlast;
            prev_stall = arvalid && !arready;
            prev_addr  = araddr;
            prev_len   = arlen;
            dec = rl && cnt > 0;
            if (hs) begin
                chk("arsize", arsize, 3'b111);
                chk("arburst", arburst, 2'b01);
                chk("arid", arid, 0);
                log_addr.push_back(araddr);
                hs_count++;
                if (exp_q.size() > 0) begin
                    rq.push_back(int'(exp_q[0].len) + 1);
                    void'(exp_q.pop_front());
                    cnt++;
                end
            end
            if (dec) cnt--;
            if (rvalid && rready && rq.size() > 0) begin
                rq[0] = rq[0] - 1;
                if (rq[0] == 0) void'(rq.pop_front());
            end
            nd = 0;
            if (m_active && exp_q.size() == 0 && cnt == 0) begin
                nd = 1;
                m_active = 0;
            end
            cur_busy = m_busy;
            if (m_done) m_busy = 0;
            if (start_pulse && !cur_busy) begin
                b = {src_base_addr[63:9], 9'b0};
                e.addr = b; e.len = 8'd0;
                exp_q.push_back(e);
                for (int i = 0; i < int'(mb_total); i++) begin
                    e.addr = b + 64'd512 * 64'(i + 1);
                    e.len  = 8'd2;
                    exp_q.push_back(e);
                end
                m_active = 1;
                m_busy   = 1;
            end
            m_done = nd;
        end
    end

    // Stimulus driver: AR ready, the R-channel responder and start pulses, applied after each rising edge
    always @(posedge clk) begin
        #1;
        arready = (ar_mode == 0) ? 1'b1 : (ar_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        rvalid = 0; rready = 0; rlast = 0;
        if (rq.size() > 0) begin
            if (r_mode == 1) begin
                rvalid = 1; rready = 1;
            end else if (r_mode == 2) begin
                rvalid = 1'($urandom_range(0, 1));
                rready = ($urandom_range(0, 3) != 0);
            end
            rlast = (rq[0] == 1);
        end else if (r_mode == 2 && $urandom_range(0, 7) == 0) begin
            rvalid = 1; rready = 1; rlast = 1;
        end
        if (go) begin
            start_pulse = 1; src_base_addr = job_base; mb_total = job_n; go = 0;
        end else if (spur_en && m_busy && $urandom_range(0, 15) == 0) begin
            start_pulse = 1; src_base_addr = {$urandom, $urandom};
            mb_total = 16'($urandom_range(0, 20));
        end else begin
            start_pulse = 0;
        end
    end

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((m_busy || m_done) && t < budget) begin
            @(negedge clk); #1; t++;
        end
        if (m_busy) chk("job_timeout", busy, 0);
    endtask

    task automatic run_job(input logic [63:0] b, input int n, input bit wait_done);
        int t = 0;
        log_addr.delete();
        hs_count = 0;
        job_base = b;
        job_n    = 16'(n);
        go       = 1;
        while ((go || !m_busy) && t < 50) begin
            @(negedge clk); #1; t++;
        end
        if (!m_busy) chk("start_accept", busy, 1);
        if (wait_done) wait_idle(3000);
    endtask

    initial begin
        int t;
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_arid", arid, 0);
        chk("rst_arsize", arsize, 3'b111);
        chk("rst_arburst", arburst, 2'b01);
        repeat (3) @(posedge clk);
        #2 rst_n = 1;

        // two macroblocks, prompt returns
        ar_mode = 0; r_mode = 1;
        run_job(64'h1000_0000, 2, 1);
        chk("t1_count", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            chk("t1_param", log_addr[0], 64'h1000_0000);
            chk("t1_mb0", log_addr[1], 64'h1000_0200);
            chk("t1_mb1", log_addr[2], 64'h1000_0400);
        end

        // no macroblocks
        run_job(64'h2000_0000, 0, 1);
        chk("t2_count", log_addr.size(), 1);

        // outstanding cap with no returns
        r_mode = 0;
        run_job(64'h3000_0000, 8, 0);
        repeat (20) @(negedge clk);
        #1;
        chk("t3_cap_hs", hs_count, MAXO);
        chk("t3_cap_arvalid", arvalid, 0);
        r_mode = 1;
        wait_idle(3000);
        chk("t3_total", hs_count, 9);

        // arready held low
        ar_mode = 2;
        run_job(64'h4000_0000, 3, 0);
        repeat (5) @(negedge clk);
        #1;
        chk("t4_no_hs", hs_count, 0);
        chk("t4_valid", arvalid, 1);
        ar_mode = 1;
        wait_idle(3000);
        chk("t4_total", hs_count, 4);

        // unaligned base; returns overlap new issues
        ar_mode = 0;
        run_job(64'h1000_01FF, 3, 1);
        if (log_addr.size() > 0) chk("t5_mask", log_addr[0], 64'h1000_0000);
        else chk("t5_count", log_addr.size(), 4);

        // reset mid-job
        r_mode = 0;
        run_job(64'h5000_0000, 5, 0);
        t = 0;
        while (hs_count < 3 && t < 200) begin
            @(negedge clk); #1; t++;
        end
        if (hs_count < 3) chk("t6_wait_hs", hs_count, 3);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("t6_arvalid", arvalid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_araddr", araddr, 0);
        chk("t6_arlen", arlen, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        r_mode = 1;
        run_job(64'h6000_0000, 2, 1);
        chk("t6_restart_count", log_addr.size(), 3);
        if (log_addr.size() > 0) chk("t6_restart_param", log_addr[0], 64'h6000_0000);

        // randomized jobs with stray starts and random handshakes
        spur_en = 1; ar_mode = 1;
        for (int j = 0; j < 10; j++) begin
            r_mode = ($urandom_range(0, 1) == 0) ? 1 : 2;
            run_job({$urandom, $urandom}, $urandom_range(0, 12), 1);
        end
        spur_en = 0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
